// File: rtl/ld_st_pkg.sv
// Shared definitions for the load/store sequencer: state encoding, opcode
// values and the datapath geometry.
package ld_st_pkg;

    localparam int ADDR_W   = 9;
    localparam int NREG     = 16;
    localparam int WAIT_MAX = 15;

    localparam logic OP_LD = 1'b0;
    localparam logic OP_ST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_RD   = 3'd2,
        ST_WB   = 3'd3,
        ST_SRC  = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

endpackage

// File: rtl/reg_onehot_dec.sv
// Register-index decoder: turns a 4-bit register index plus an enable into a
// one-hot register-file strobe vector (all zero when disabled).
module reg_onehot_dec
    import ld_st_pkg::*;
(
    input  logic [3:0]      idx,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    localparam logic [NREG-1:0] ONE_C = {{(NREG-1){1'b0}}, 1'b1};

    // Place a single bit at the selected index, or drive nothing when idle.
    always_comb begin
        onehot = {NREG{1'b0}};
        if (en) begin
            onehot = ONE_C << idx;
        end else begin
            onehot = {NREG{1'b0}};
        end
    end

endmodule

// File: rtl/ld_st_sequencer.sv
// Load/store sequencer: walks a single-bus datapath through one memory
// transfer (load: ADDR-RD-WB-DONE, store: ADDR-SRC-WR-DONE).
// Optional build macro MEM_WAIT_EN: RD/WR stall until mem_ready, with a
// 4-bit wait counter that aborts the transfer with an err pulse on timeout.
module ld_st_sequencer
    import ld_st_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              op,
    input  logic [3:0]        rsel,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              Read,
    output logic              Write,
    output logic [NREG-1:0]   Rin,
    output logic [NREG-1:0]   Rout,
    output logic [ADDR_W-1:0] Address
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              accept_s;
    logic              op_r;
    logic [3:0]        rsel_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic              rin_en_r;
    logic              rout_en_r;

`ifdef MEM_WAIT_EN
    localparam logic [3:0] WAIT_LAST_C = 4'(WAIT_MAX - 1);
    logic [3:0] wait_cnt_r;
    logic       timeout_s;
`else
    logic       unused_mem_ready_s;
    assign unused_mem_ready_s = mem_ready;
`endif

    assign accept_s   = (state_r == ST_IDLE) && start;
    // The address going out with ADDR is the one being captured on that edge.
    assign addr_nxt_s = accept_s ? addr_in : addr_r;

    // Next-state selection; the access states may stall on memory when enabled.
    always_comb begin
        state_nxt_s = state_r;
`ifdef MEM_WAIT_EN
        timeout_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (op_r == OP_ST) begin
                    state_nxt_s = ST_SRC;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RD: begin
`ifdef MEM_WAIT_EN
                if (mem_ready) begin
                    state_nxt_s = ST_WB;
                end else if (wait_cnt_r == WAIT_LAST_C) begin
                    state_nxt_s = ST_IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RD;
                end
`else
                state_nxt_s = ST_WB;
`endif
            end
            ST_WB:   state_nxt_s = ST_DONE;
            ST_SRC:  state_nxt_s = ST_WR;
            ST_WR: begin
`ifdef MEM_WAIT_EN
                if (mem_ready) begin
                    state_nxt_s = ST_DONE;
                end else if (wait_cnt_r == WAIT_LAST_C) begin
                    state_nxt_s = ST_IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WR;
                end
`else
                state_nxt_s = ST_DONE;
`endif
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, request latch and Moore outputs registered from the next state.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r   <= ST_IDLE;
            op_r      <= 1'b0;
            rsel_r    <= 4'd0;
            addr_r    <= {ADDR_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            MARin     <= 1'b0;
            MDRin     <= 1'b0;
            MDRout    <= 1'b0;
            Read      <= 1'b0;
            Write     <= 1'b0;
            rin_en_r  <= 1'b0;
            rout_en_r <= 1'b0;
            Address   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_r   <= op;
                rsel_r <= rsel;
                addr_r <= addr_in;
            end
            busy      <= (state_nxt_s != ST_IDLE);
            done      <= (state_nxt_s == ST_DONE);
            MARin     <= (state_nxt_s == ST_ADDR);
            MDRin     <= (state_nxt_s == ST_RD) || (state_nxt_s == ST_SRC);
            MDRout    <= (state_nxt_s == ST_WB);
            Read      <= (state_nxt_s == ST_RD);
            Write     <= (state_nxt_s == ST_WR);
            rin_en_r  <= (state_nxt_s == ST_WB);
            rout_en_r <= (state_nxt_s == ST_SRC);
            Address   <= (state_nxt_s != ST_IDLE) ? addr_nxt_s : {ADDR_W{1'b0}};
`ifdef MEM_WAIT_EN
            err       <= timeout_s;
`else
            err       <= 1'b0;
`endif
        end
    end

`ifdef MEM_WAIT_EN
    // Count stalled access cycles; any state change restarts the count.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wait_cnt_r <= 4'd0;
        end else if (state_nxt_s != state_r) begin
            wait_cnt_r <= 4'd0;
        end else if (((state_r == ST_RD) || (state_r == ST_WR)) && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end
    end
`endif

    reg_onehot_dec u_rin_dec (
        .idx    (rsel_r),
        .en     (rin_en_r),
        .onehot (Rin)
    );

    reg_onehot_dec u_rout_dec (
        .idx    (rsel_r),
        .en     (rout_en_r),
        .onehot (Rout)
    );

endmodule

// File: doc/ld_st_sequencer.md
LD_ST_SEQUENCER -- requirements
Module: ld_st_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clock  in  1  rising-edge clock`; `clear  in  1  asynchronous active-low reset`.
REQ-002 start  in  1  request strobe, sampled only in IDLE.
REQ-003 op  in  1  0=load (memory->register), 1=store (register->memory).
REQ-004 rsel  in  4  target/source register index R0..R15.
REQ-005 addr_in  in  9  memory word address.
REQ-006 mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN).
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse, transfer complete.
REQ-009 err  out  1  one-cycle pulse, wait timeout (MEM_WAIT_EN only).
REQ-010 MARin, MDRin, MDRout, Read, Write  out  1 each  datapath memory controls.
REQ-011 Rin  out  16  one-hot register load enables.
REQ-012 Rout  out  16  one-hot register bus-drive enables.
REQ-013 Address  out  9  latched address to MAR.

Function
REQ-014 On accept (IDLE and start=1), the block SHALL latch op, rsel and addr_in; the latched values SHALL hold until the block returns to IDLE.
REQ-015 States SHALL be IDLE, ADDR, RD, WB, SRC, WR, DONE.
REQ-016 State transitions SHALL be:
- Load: IDLE->ADDR->RD->WB->DONE->IDLE.
- Store: IDLE->ADDR->SRC->WR->DONE->IDLE.
REQ-017 Outputs SHALL be Moore-decoded from registered state and latched fields only.
REQ-018 The states SHALL assert:
- ADDR: MARin=1, Address=latched addr.
- RD: Read=1, MDRin=1.
- WB: MDRout=1, Rin[rsel]=1.
- SRC: Rout[rsel]=1, MDRin=1.
- WR: Write=1.
- DONE: done=1.
- All other outputs 0.
REQ-019 Address SHALL hold the latched address from ADDR through DONE, and SHALL be 0 in IDLE.
REQ-020 Latency with no wait states SHALL be 4 cycles from the accept edge to the done pulse; back-to-back accept SHALL be possible in the cycle after DONE.
REQ-021 start while busy SHALL be ignored and not queued.
REQ-022 Rin and Rout SHALL never both be nonzero; MDRout and Rout SHALL never be asserted together.
REQ-023 Read and Write SHALL never be asserted together.

Reset
REQ-024 While clear=0, the state SHALL be IDLE, the latched fields and wait counter SHALL be 0, and all outputs SHALL be 0.
REQ-025 Reset mid-operation SHALL abort immediately, with no done and no err pulse.
REQ-026 After clear deasserts, the first accept SHALL be possible on the next rising edge.

Configuration
REQ-027 With MEM_WAIT_EN defined, RD and WR SHALL remain in place, keeping their controls asserted, until mem_ready=1, then advance.
REQ-028 With MEM_WAIT_EN defined, a 4-bit wait counter SHALL count the cycles spent in RD/WR without mem_ready.
REQ-029 With MEM_WAIT_EN defined, if the wait counter reaches WAIT_MAX=15, the block SHALL pulse err for one cycle in place of done, return to IDLE, and perform no WB; the counter SHALL clear on every state change.
REQ-030 Without MEM_WAIT_EN, RD and WR SHALL last exactly one cycle, mem_ready SHALL be ignored, err SHALL be tied 0, and no counter SHALL be built.

Structure
REQ-031 A shared package ld_st_pkg SHALL hold:
- state enum;
- OP_LD=0, OP_ST=1;
- ADDR_W=9, NREG=16, WAIT_MAX=15.
REQ-032 One sub-module, reg_onehot_dec (4-bit index plus enable -> 16-bit one-hot), SHALL be instantiated twice, once for Rin and once for Rout.
REQ-033 The block SHALL be synthesizable and free of latches.

Verification
REQ-034 Load: op=0, rsel=4, addr=5, mem_ready=1 -> MARin with Address=5 on cycle 1, Read+MDRin on cycle 2, MDRout+Rin=0x0010 on cycle 3, done on cycle 4.
REQ-035 Store: op=1, rsel=15, addr=0x1FF -> Rout=0x8000+MDRin, then Write, then done; Address=0x1FF throughout.
REQ-036 Busy ignore: second start during the load at cycle 2 -> exactly one done; latched rsel is unchanged.
REQ-037 Wait states (MEM_WAIT_EN): mem_ready low 3 cycles in RD -> Read held 4 cycles, done at cycle 7; mem_ready never high -> err after 15 wait cycles, Rin stays 0.
REQ-038 Reset mid-op: clear=0 during WR -> all outputs 0 asynchronously, no done; new store after release completes normally.
REQ-039 Assertions SHALL hold on every cycle: Rin/Rout mutual exclusion, Read/Write mutual exclusion, and $onehot0 on Rin and on Rout.
